// File: rtl/sopc_pio_pkg.sv
// Shared constants for the SOPC input PIO.
// - Register word addresses as seen on the Avalon-MM slave port.
// - Edge-mode selectors for the edge-capture logic.
// - edge_sel(): returns the per-bit edge hits for a given mode.
package sopc_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // cur is the debounced value, prev is its one-cycle delayed copy.
  function automatic logic [31:0] edge_sel(input int          mode,
                                           input logic [31:0] cur,
                                           input logic [31:0] prev);
    logic [31:0] hit;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      default:   hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sopc_pio_debounce.sv
// One input channel: 2-FF synchroniser followed by a stability counter and
// the debounced output register.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   din      asynchronous external input
//   raw      synchroniser output (not debounced)
//   deb      debounced output
module sopc_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic deb
);

  logic sync_p0;
  logic sync_p1;
  logic deb_p2;

  // Stage 0/1: synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounced register
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb_p2 <= 1'b0;
        else          deb_p2 <= sync_p1;
      end
    end else begin : g_count
      localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // The counter measures how long sync has disagreed with deb; any
      // agreeing cycle restarts the measurement, so short glitches vanish.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt    <= '0;
          deb_p2 <= 1'b0;
        end else if (sync_p1 != deb_p2) begin
          if (cnt == CNT_LAST) begin
            deb_p2 <= sync_p1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  endgenerate

  assign raw = sync_p1;
  assign deb = deb_p2;

endmodule

// File: rtl/sopc_pio_in_irq.sv
// Avalon-MM input PIO with per-channel debounce, sticky edge capture and a
// maskable level interrupt. Zero-wait-state slave, read latency 1.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[1:0]          word address (DATA, IRQ_MASK, EDGE_CAP, RAW)
//   chipselect, write_n   slave select and active-low write strobe
//   writedata[31:0]       write data
//   in_port[WIDTH-1:0]    asynchronous external inputs
//   readdata[31:0]        registered read data
//   irq                   level interrupt, active high
module sopc_pio_in_irq #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  import sopc_pio_pkg::*;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] deb_p2;
  logic [WIDTH-1:0] deb_p3;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Stages 0..2: per-channel synchroniser and debounce
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sopc_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .raw    (raw[i]),
      .deb    (deb_p2[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;
  assign edge_hit     = WIDTH'(edge_sel(EDGE_MODE, 32'(deb_p2), 32'(deb_p3)));
  assign edge_clr     = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(deb_p2);
      ADDR_MASK: rd_mux = 32'(irq_mask);
      ADDR_EDGE: rd_mux = 32'(edge_cap);
      ADDR_RAW:  rd_mux = 32'(raw);
      default:   rd_mux = '0;
    endcase
  end

  // Stage 3: delayed deb, edge capture, mask and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_p3   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      deb_p3 <= deb_p2;
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      // Set is applied after clear so a coincident new edge survives.
      edge_cap <= (edge_cap & ~edge_clr) | edge_hit;
      readdata <= rd_mux;
    end
  end

  // Purely register-driven: no path from in_port or the bus to irq.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sopc_pio_in_irq.sv
module tb_sopc_pio_in_irq;
  import sopc_pio_pkg::*;

  localparam int W  = 4;
  localparam int DB = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '0;
  logic [W-1:0]  in_port_r  = '0;
  logic [31:0]   readdata;
  logic [31:0]   readdata_r;
  logic          irq;
  logic          irq_r;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          alt;
  } rd_exp_t;

  rd_exp_t sb[$];

  always #5 clk = ~clk;

  sopc_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(EDGE_ANY)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Rising-only build sharing the bus with the main instance.
  sopc_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(EDGE_RISE)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_r),
    .readdata(readdata_r), .irq(irq_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; a read issued in the previous cycle is scored here.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.alt) check(e.tag, readdata_r, e.exp);
      else       check(e.tag, readdata, e.exp);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag,
                    input bit alt = 1'b0);
    rd_exp_t e;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    e.tag = tag;
    e.exp = exp;
    e.alt = alt;
    sb.push_back(e);
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst readdata", readdata, 32'h0);
    check("rst irq", irq, 32'h0);
    reset_n = 1'b1;

    rd(ADDR_DATA, 32'h0, "rst DATA");
    rd(ADDR_MASK, 32'h0, "rst MASK");
    rd(ADDR_EDGE, 32'h0, "rst EDGE");
    rd(ADDR_RAW,  32'h0, "rst RAW");
    check("rst irq after reads", irq, 32'h0);
    check("rst irq_r", irq_r, 32'h0);

    // Step 0 -> 5; each rd below occupies one cycle, starting at cycle 0.
    in_port = 4'h5;
    rd(ADDR_RAW,  32'h0, "step RAW c0");
    rd(ADDR_RAW,  32'h0, "step RAW c1");
    rd(ADDR_RAW,  32'h5, "step RAW c2");
    rd(ADDR_DATA, 32'h0, "step DATA c3");
    rd(ADDR_DATA, 32'h0, "step DATA c4");
    rd(ADDR_DATA, 32'h0, "step DATA c5");
    rd(ADDR_DATA, 32'h5, "step DATA c6");
    rd(ADDR_EDGE, 32'h5, "step EDGE c7");
    check("step irq mask0", irq, 32'h0);
    wr(ADDR_MASK, 32'h1);
    check("step irq mask1", irq, 32'h1);
    rd(ADDR_MASK, 32'h1, "step MASK");

    // Bit-1 glitch lasting 3 synced cycles.
    in_port = 4'h7;
    idle(3);
    in_port = 4'h5;
    for (int i = 0; i < 4; i++) rd(ADDR_DATA, 32'h5, "glitch DATA during");
    idle(8);
    rd(ADDR_DATA, 32'h5, "glitch DATA after");
    rd(ADDR_EDGE, 32'h5, "glitch EDGE after");

    // W1C behaviour.
    in_port = 4'hF;
    idle(8);
    rd(ADDR_EDGE, 32'hF, "w1c EDGE full");
    wr(ADDR_EDGE, 32'h3);
    rd(ADDR_EDGE, 32'hC, "w1c clear 3");
    wr(ADDR_EDGE, 32'h4);
    rd(ADDR_EDGE, 32'h8, "w1c clear 4");
    // Bit-2 falling edge lands in cycle 7; the clear is issued in cycle 6.
    in_port = 4'hB;
    idle(6);
    wr(ADDR_EDGE, 32'h4);
    rd(ADDR_EDGE, 32'hC, "w1c set wins");
    rd(ADDR_EDGE, 32'hC, "w1c set holds");

    // Rising-only instance.
    in_port_r = 4'h1;
    idle(8);
    wr(ADDR_EDGE, 32'hF);
    in_port_r = 4'h0;
    idle(8);
    rd(ADDR_EDGE, 32'h0, "rise fall ignored", 1'b1);
    check("rise irq_r low", irq_r, 32'h0);
    in_port_r = 4'h1;
    idle(8);
    rd(ADDR_EDGE, 32'h1, "rise captured", 1'b1);
    check("rise irq_r high", irq_r, 32'h1);

    // Reset in the middle of a debounce count.
    in_port = 4'h0;
    idle(8);
    rd(ADDR_EDGE, 32'hB, "pre-rst EDGE");
    wr(ADDR_MASK, 32'hF);
    check("pre-rst irq", irq, 32'h1);
    in_port = 4'h1;
    idle(4);
    check("pre-rst readdata", readdata, 32'hF);
    reset_n = 1'b0;
    #2;
    check("mid-rst readdata", readdata, 32'h0);
    check("mid-rst irq", irq, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(5);
    rd(ADDR_DATA, 32'h0, "post-rst DATA c5");
    rd(ADDR_DATA, 32'h1, "post-rst DATA c6");
    rd(ADDR_EDGE, 32'h1, "post-rst EDGE c7");
    rd(ADDR_MASK, 32'h0, "post-rst MASK");
    check("post-rst irq", irq, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
